// File: rtl/de2_sram_pkg.sv
// Shared types for the DE2 asynchronous SRAM: sequencer states, bus widths and the
// registered pin bundle that the DE2 top level also uses.
package de2_sram_pkg;

    localparam int SRAM_AW = 12;
    localparam int SRAM_DW = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } sram_state_e;

    typedef struct packed {
        logic               ce_n;
        logic               oe_n;
        logic               we_n;
        logic [1:0]         be_n;
        logic [SRAM_AW-1:0] addr;
        logic [SRAM_DW-1:0] dq;
        logic               dqe;
    } de2_sram_out_t;

    localparam de2_sram_out_t SRAM_OUT_RESET = '{
        ce_n: 1'b1,
        oe_n: 1'b1,
        we_n: 1'b1,
        be_n: 2'b11,
        addr: '0,
        dq:   '0,
        dqe:  1'b0
    };

endpackage

// File: rtl/de2_sram_rr_grant.sv
// Combinational two-way grant selector for the SRAM arbiter.
// DE2_SRAM_ARBITER_ROUND_ROBIN_EN selects round-robin; otherwise port 0 has fixed priority.
module de2_sram_rr_grant (
    input  logic req0_valid,
    input  logic req1_valid,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant
);

`ifdef DE2_SRAM_ARBITER_ROUND_ROBIN_EN
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant       = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end
    end
`else
    // last_grant is still tracked by the parent but plays no part in fixed priority.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant       = ~req0_valid & req1_valid;
    end
`endif

endmodule

// File: rtl/de2_sram_arbiter.sv
// Two-port arbiter and setup/access/done cycle sequencer for the DE2 asynchronous SRAM.
// Grant policy is set inside de2_sram_rr_grant by DE2_SRAM_ARBITER_ROUND_ROBIN_EN.
module de2_sram_arbiter
    import de2_sram_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    input  logic               req0_write,
    input  logic [SRAM_AW-1:0] req0_addr,
    input  logic [1:0]         req0_be_n,
    input  logic [SRAM_DW-1:0] req0_wdata,
    output logic               req0_ack,
    input  logic               req1_valid,
    input  logic               req1_write,
    input  logic [SRAM_AW-1:0] req1_addr,
    input  logic [1:0]         req1_be_n,
    input  logic [SRAM_DW-1:0] req1_wdata,
    output logic               req1_ack,
    output logic [SRAM_DW-1:0] rdata,
    input  logic [SRAM_DW-1:0] de2_sram_in__dq,
    output logic               de2_sram_out__ce_n,
    output logic               de2_sram_out__oe_n,
    output logic               de2_sram_out__we_n,
    output logic [1:0]         de2_sram_out__be_n,
    output logic [SRAM_AW-1:0] de2_sram_out__addr,
    output logic [SRAM_DW-1:0] de2_sram_out__dq,
    output logic               de2_sram_out__dqe
);

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    sram_state_e        state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    de2_sram_out_t      pins_q, pins_d;
    logic               write_q, write_d;
    logic               last_grant_q, last_grant_d;
    logic               req0_ack_q, req0_ack_d;
    logic               req1_ack_q, req1_ack_d;
    logic [SRAM_DW-1:0] rdata_q, rdata_d;

    logic               grant_valid;
    logic               grant;
    logic               sel_write;
    logic [SRAM_AW-1:0] sel_addr;
    logic [1:0]         sel_be_n;
    logic [SRAM_DW-1:0] sel_wdata;

    de2_sram_rr_grant u_grant (
        .req0_valid  (req0_valid),
        .req1_valid  (req1_valid),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    assign sel_write = grant ? req1_write : req0_write;
    assign sel_addr  = grant ? req1_addr  : req0_addr;
    assign sel_be_n  = grant ? req1_be_n  : req0_be_n;
    assign sel_wdata = grant ? req1_wdata : req0_wdata;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pins_d       = pins_q;
        write_d      = write_q;
        last_grant_d = last_grant_q;
        rdata_d      = rdata_q;
        req0_ack_d   = 1'b0;
        req1_ack_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d      = SETUP;
                    last_grant_d = grant;
                    write_d      = sel_write;
                    pins_d.ce_n  = 1'b0;
                    pins_d.oe_n  = sel_write;
                    pins_d.we_n  = 1'b1;
                    pins_d.be_n  = sel_be_n;
                    pins_d.addr  = sel_addr;
                    pins_d.dqe   = sel_write;
                    if (sel_write) begin
                        pins_d.dq = sel_wdata;
                    end
                end
            end
            SETUP: begin
                // Address and data have had one cycle to settle before the write strobe.
                state_d     = ACCESS;
                cnt_d       = CNT_LOAD;
                pins_d.we_n = ~write_q;
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d     = DONE;
                    pins_d.we_n = 1'b1;
                    pins_d.oe_n = 1'b1;
                    req0_ack_d  = ~last_grant_q;
                    req1_ack_d  = last_grant_q;
                    if (!write_q) begin
                        rdata_d = de2_sram_in__dq;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                // Data and address were held through DONE; release the bus now.
                state_d     = IDLE;
                pins_d.ce_n = 1'b1;
                pins_d.be_n = 2'b11;
                pins_d.dqe  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pins_q       <= SRAM_OUT_RESET;
            write_q      <= 1'b0;
            last_grant_q <= 1'b1;
            req0_ack_q   <= 1'b0;
            req1_ack_q   <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pins_q       <= pins_d;
            write_q      <= write_d;
            last_grant_q <= last_grant_d;
            req0_ack_q   <= req0_ack_d;
            req1_ack_q   <= req1_ack_d;
            rdata_q      <= rdata_d;
        end
    end

    assign req0_ack           = req0_ack_q;
    assign req1_ack           = req1_ack_q;
    assign rdata              = rdata_q;
    assign de2_sram_out__ce_n = pins_q.ce_n;
    assign de2_sram_out__oe_n = pins_q.oe_n;
    assign de2_sram_out__we_n = pins_q.we_n;
    assign de2_sram_out__be_n = pins_q.be_n;
    assign de2_sram_out__addr = pins_q.addr;
    assign de2_sram_out__dq   = pins_q.dq;
    assign de2_sram_out__dqe  = pins_q.dqe;

endmodule

// File: tb/tb_de2_sram_arbiter.sv
// Bench for de2_sram_arbiter: directed vector table, multi-cycle corner sequences and a
// randomized run against a transaction-level reference model and SRAM memory model.
module tb_de2_sram_arbiter;

    localparam int AC     = 2;
    localparam int AC_MIN = 1;
`ifdef DE2_SRAM_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_write, req1_valid, req1_write;
    logic [11:0] req0_addr, req1_addr;
    logic [1:0]  req0_be_n, req1_be_n;
    logic [15:0] req0_wdata, req1_wdata;
    logic        req0_ack, req1_ack;
    logic [15:0] rdata, sram_dq_in, sram_dq;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_dqe;
    logic [1:0]  sram_be_n;
    logic [11:0] sram_addr;

    logic        m_req0_valid, m_req0_write, m_req1_valid, m_req1_write;
    logic [11:0] m_req0_addr, m_req1_addr;
    logic [1:0]  m_req0_be_n, m_req1_be_n;
    logic [15:0] m_req0_wdata, m_req1_wdata;
    logic        m_req0_ack, m_req1_ack;
    logic [15:0] m_rdata, m_dq_in, m_dq;
    logic        m_ce_n, m_oe_n, m_we_n, m_dqe;
    logic [1:0]  m_be_n;
    logic [11:0] m_addr;

    always #5 clk = ~clk;

    de2_sram_arbiter #(.ACCESS_CYCLES(AC)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_be_n(req0_be_n), .req0_wdata(req0_wdata), .req0_ack(req0_ack),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_be_n(req1_be_n), .req1_wdata(req1_wdata), .req1_ack(req1_ack),
        .rdata(rdata), .de2_sram_in__dq(sram_dq_in),
        .de2_sram_out__ce_n(sram_ce_n), .de2_sram_out__oe_n(sram_oe_n),
        .de2_sram_out__we_n(sram_we_n), .de2_sram_out__be_n(sram_be_n),
        .de2_sram_out__addr(sram_addr), .de2_sram_out__dq(sram_dq),
        .de2_sram_out__dqe(sram_dqe)
    );

    de2_sram_arbiter #(.ACCESS_CYCLES(AC_MIN)) dut_min (
        .clk(clk), .reset(reset),
        .req0_valid(m_req0_valid), .req0_write(m_req0_write), .req0_addr(m_req0_addr),
        .req0_be_n(m_req0_be_n), .req0_wdata(m_req0_wdata), .req0_ack(m_req0_ack),
        .req1_valid(m_req1_valid), .req1_write(m_req1_write), .req1_addr(m_req1_addr),
        .req1_be_n(m_req1_be_n), .req1_wdata(m_req1_wdata), .req1_ack(m_req1_ack),
        .rdata(m_rdata), .de2_sram_in__dq(m_dq_in),
        .de2_sram_out__ce_n(m_ce_n), .de2_sram_out__oe_n(m_oe_n),
        .de2_sram_out__we_n(m_we_n), .de2_sram_out__be_n(m_be_n),
        .de2_sram_out__addr(m_addr), .de2_sram_out__dq(m_dq),
        .de2_sram_out__dqe(m_dqe)
    );

    // Asynchronous SRAM model: read data while selected and output-enabled, byte writes while strobed.
    logic [15:0] mem [0:4095];
    logic        pl_en;
    logic [11:0] pl_addr;
    logic [15:0] pl_data;

    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'hDEAD;
    assign m_dq_in    = (!m_ce_n && !m_oe_n) ? ({4'h0, m_addr} ^ 16'hA5A5) : 16'h0000;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (!sram_ce_n && !sram_we_n && sram_dqe) begin
            if (!sram_be_n[0]) mem[sram_addr][7:0]  <= sram_dq[7:0];
            if (!sram_be_n[1]) mem[sram_addr][15:8] <= sram_dq[15:8];
        end
    end

    typedef struct {
        int          port;
        logic        write;
        logic [11:0] addr;
        logic [1:0]  be_n;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t        vecs [7];
    vec_t        v;
    logic [15:0] shadow [0:4095];
    logic        r_valid [2];
    logic        r_write [2];
    logic [11:0] r_addr  [2];
    logic [1:0]  r_be_n  [2];
    logic [15:0] r_wdata [2];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          c0, c1, n0, n1, lat, p, w, last_w, free_at, exp_ack, exp_port, we_cnt;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input int port, input logic valid, input logic write,
                                 input logic [11:0] addr, input logic [1:0] be_n, input logic [15:0] wdata);
        r_valid[port] = valid;
        r_write[port] = write;
        r_addr[port]  = addr;
        r_be_n[port]  = be_n;
        r_wdata[port] = wdata;
        if (port == 0) begin
            req0_valid = valid; req0_write = write; req0_addr = addr; req0_be_n = be_n; req0_wdata = wdata;
        end else begin
            req1_valid = valid; req1_write = write; req1_addr = addr; req1_be_n = be_n; req1_wdata = wdata;
        end
    endtask

    task automatic dropValid(input int port);
        applyStimulus(port, 1'b0, r_write[port], r_addr[port], r_be_n[port], r_wdata[port]);
    endtask

    task automatic shadowWrite(input logic [11:0] addr, input logic [1:0] be_n, input logic [15:0] data);
        if (!be_n[0]) shadow[addr][7:0]  = data[7:0];
        if (!be_n[1]) shadow[addr][15:8] = data[15:8];
    endtask

    task automatic preload(input logic [11:0] addr, input logic [15:0] data);
        pl_en = 1'b1; pl_addr = addr; pl_data = data;
        tick();
        pl_en = 1'b0;
        shadow[addr] = data;
    endtask

    // Expected {ce_n, oe_n, we_n, dqe, ack0, ack1} at cycle N+t of a single transfer.
    function automatic logic [5:0] expCtl(input int t, input int ac, input logic wr, input int port);
        logic ce_e, oe_e, we_e, dqe_e, a0_e, a1_e;
        ce_e  = !(t >= 1 && t <= ac + 2);
        oe_e  = !(!wr && t >= 1 && t <= ac + 1);
        we_e  = !(wr && t >= 2 && t <= ac + 1);
        dqe_e = wr && t >= 1 && t <= ac + 2;
        a0_e  = (t == ac + 2) && (port == 0);
        a1_e  = (t == ac + 2) && (port == 1);
        return {ce_e, oe_e, we_e, dqe_e, a0_e, a1_e};
    endfunction

    task automatic doReset();
        reset = 1'b1;
        tick();
        tick();
        checkOutput("rst_ctl", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dqe, req0_ack, req1_ack}), 32'h38);
        checkOutput("rst_be_n", 32'(sram_be_n), 32'h3);
        checkOutput("rst_addr", 32'(sram_addr), 32'h0);
        checkOutput("rst_dq", 32'(sram_dq), 32'h0);
        checkOutput("rst_rdata", 32'(rdata), 32'h0);
        checkOutput("rst_min_ctl", 32'({m_ce_n, m_oe_n, m_we_n, m_dqe, m_req0_ack, m_req1_ack}), 32'h38);
        checkOutput("rst_min_rdata", 32'(m_rdata), 32'h0);
        reset = 1'b0;
    endtask

    task automatic runTransfer(input vec_t tv, input bit already_valid);
        if (!already_valid) applyStimulus(tv.port, 1'b1, tv.write, tv.addr, tv.be_n, tv.wdata);
        for (int t = 1; t <= AC + 3; t++) begin
            tick();
            checkOutput("xfer_ctl", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dqe, req0_ack, req1_ack}),
                        32'(expCtl(t, AC, tv.write, tv.port)));
            if (t == 1) begin
                checkOutput("xfer_addr", 32'(sram_addr), 32'(tv.addr));
                checkOutput("xfer_be_n", 32'(sram_be_n), 32'(tv.be_n));
            end
            if (tv.write && (t == 1 || t == AC + 2)) checkOutput("xfer_dq", 32'(sram_dq), 32'(tv.wdata));
            if (t == AC + 2) begin
                checkOutput("xfer_rdata", 32'(rdata), 32'(tv.exp_rdata));
                dropValid(tv.port);
                if (tv.write) shadowWrite(tv.addr, tv.be_n, tv.wdata);
            end
        end
    endtask

    task automatic measurePair(output int a0_at, output int a1_at);
        a0_at = -1;
        a1_at = -1;
        for (int t = 1; t <= 3 * (AC + 3); t++) begin
            tick();
            if (req0_ack && a0_at < 0) begin
                a0_at = t;
                checkOutput("pair_rdata0", 32'(rdata), 32'(shadow[r_addr[0]]));
                dropValid(0);
            end
            if (req1_ack && a1_at < 0) begin
                a1_at = t;
                checkOutput("pair_rdata1", 32'(rdata), 32'(shadow[r_addr[1]]));
                dropValid(1);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        applyStimulus(0, 1'b0, 1'b0, 12'h0, 2'b11, 16'h0);
        applyStimulus(1, 1'b0, 1'b0, 12'h0, 2'b11, 16'h0);
        m_req0_valid = 1'b0; m_req0_write = 1'b0; m_req0_addr = '0; m_req0_be_n = 2'b00; m_req0_wdata = '0;
        m_req1_valid = 1'b0; m_req1_write = 1'b0; m_req1_addr = '0; m_req1_be_n = 2'b11; m_req1_wdata = '0;
        doReset();

        for (int a = 0; a < 16; a++) preload(12'(32'h100 + a), 16'($urandom));
        preload(12'h123, 16'hBEEF);
        preload(12'h0FF, 16'h1111);

        vecs[0] = '{0, 1'b0, 12'h123, 2'b00, 16'h0000, 16'hBEEF};
        vecs[1] = '{1, 1'b1, 12'h0FF, 2'b10, 16'h5A5A, 16'hBEEF};
        vecs[2] = '{0, 1'b0, 12'h0FF, 2'b00, 16'h0000, 16'h115A};
        vecs[3] = '{1, 1'b1, 12'h123, 2'b01, 16'h7700, 16'h115A};
        vecs[4] = '{1, 1'b0, 12'h123, 2'b00, 16'h0000, 16'h77EF};
        vecs[5] = '{0, 1'b1, 12'h0FF, 2'b11, 16'hABCD, 16'h77EF};
        vecs[6] = '{0, 1'b0, 12'h0FF, 2'b00, 16'h0000, 16'h115A};
        for (int i = 0; i < 7; i++) runTransfer(vecs[i], 1'b0);

        // Simultaneous requests straight after reset, then again after a port-0-only transfer.
        doReset();
        applyStimulus(0, 1'b1, 1'b0, 12'h100, 2'b00, 16'h0);
        applyStimulus(1, 1'b1, 1'b0, 12'h101, 2'b00, 16'h0);
        measurePair(c0, c1);
        checkOutput("pair1_ack0_at", 32'(c0), 32'(AC + 2));
        checkOutput("pair1_ack1_at", 32'(c1), 32'(2 * (AC + 3) - 1));
        v = '{0, 1'b0, 12'h100, 2'b00, 16'h0, shadow[12'h100]};
        runTransfer(v, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 12'h102, 2'b00, 16'h0);
        applyStimulus(1, 1'b1, 1'b0, 12'h103, 2'b00, 16'h0);
        measurePair(c0, c1);
        checkOutput("pair2_ack0_at", 32'(c0), 32'(RR ? 2 * (AC + 3) - 1 : AC + 2));
        checkOutput("pair2_ack1_at", 32'(c1), 32'(RR ? AC + 2 : 2 * (AC + 3) - 1));

        // Port 0 never lets go while port 1 waits; then port 0 drops.
        doReset();
        applyStimulus(0, 1'b1, 1'b0, 12'h104, 2'b00, 16'h0);
        applyStimulus(1, 1'b1, 1'b0, 12'h105, 2'b00, 16'h0);
        n0 = 0;
        n1 = 0;
        for (int t = 1; t <= 3 * (AC + 3); t++) begin
            tick();
            if (req0_ack) n0++;
            if (req1_ack) begin
                n1++;
                dropValid(1);
            end
        end
        checkOutput("hold_ack0_count", 32'(n0), 32'(RR ? 2 : 3));
        checkOutput("hold_ack1_count", 32'(n1), 32'(RR ? 1 : 0));
        dropValid(0);
        applyStimulus(1, 1'b1, 1'b0, 12'h105, 2'b00, 16'h0);
        lat = -1;
        for (int t = 1; t <= 2 * (AC + 3); t++) begin
            tick();
            if (req1_ack && lat < 0) begin
                lat = t;
                dropValid(1);
            end
        end
        checkOutput("release_ack1_at", 32'(lat), 32'(AC + 2));

        // Reset during the second ACCESS cycle of a write; the held request reruns.
        v = '{0, 1'b1, 12'h105, 2'b00, 16'hCAFE, 16'h0000};
        applyStimulus(0, 1'b1, 1'b1, 12'h105, 2'b00, 16'hCAFE);
        for (int t = 1; t <= 3; t++) begin
            tick();
            checkOutput("abort_ctl", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dqe, req0_ack, req1_ack}),
                        32'(expCtl(t, AC, 1'b1, 0)));
        end
        reset = 1'b1;
        tick();
        checkOutput("abort_reset_ctl", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dqe, req0_ack, req1_ack}), 32'h38);
        reset = 1'b0;
        runTransfer(v, 1'b1);

        // Single-cycle access window on the ACCESS_CYCLES=1 instance.
        doReset();
        for (int wr = 0; wr < 2; wr++) begin
            m_req0_valid = 1'b1; m_req0_write = wr[0]; m_req0_addr = 12'h0AB; m_req0_wdata = 16'h1234;
            for (int t = 1; t <= AC_MIN + 3; t++) begin
                tick();
                checkOutput("min_ctl", 32'({m_ce_n, m_oe_n, m_we_n, m_dqe, m_req0_ack, m_req1_ack}),
                            32'(expCtl(t, AC_MIN, wr[0], 0)));
                if (t == 1) checkOutput("min_addr", 32'(m_addr), 32'h0AB);
                if (t == AC_MIN + 2) begin
                    checkOutput("min_rdata", 32'(m_rdata), 32'hA50E);
                    m_req0_valid = 1'b0;
                end
            end
        end

        // Randomized traffic against the transaction-level model.
        doReset();
        last_w   = 1;
        free_at  = cyc;
        exp_ack  = -1;
        exp_port = 0;
        we_cnt   = 0;
        for (int s = 0; s < 400; s++) begin
            tick();
            checkOutput("rnd_ack0", 32'(req0_ack), 32'(exp_ack == cyc && exp_port == 0));
            checkOutput("rnd_ack1", 32'(req1_ack), 32'(exp_ack == cyc && exp_port == 1));
            if (!sram_we_n) we_cnt++;
            if (exp_ack == cyc) begin
                p = exp_port;
                checkOutput("rnd_we_len", 32'(we_cnt), 32'(r_write[p] ? AC : 0));
                if (r_write[p]) shadowWrite(r_addr[p], r_be_n[p], r_wdata[p]);
                else checkOutput("rnd_rdata", 32'(rdata), 32'(shadow[r_addr[p]]));
                we_cnt = 0;
                dropValid(p);
            end
            for (int q = 0; q < 2; q++) begin
                if (!r_valid[q] && $urandom_range(3) == 0)
                    applyStimulus(q, 1'b1, 1'($urandom_range(1)), 12'(32'h100 + $urandom_range(15)),
                                  2'($urandom_range(3)), 16'($urandom));
            end
            if (cyc >= free_at && (r_valid[0] || r_valid[1])) begin
                w        = (r_valid[0] && r_valid[1]) ? (RR ? 1 - last_w : 0) : (r_valid[1] ? 1 : 0);
                exp_port = w;
                exp_ack  = cyc + AC + 2;
                free_at  = cyc + AC + 3;
                last_w   = w;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
